uart_tx_drain: RTL and testbench

//   Serial transmitter draining the 8-bit byte FIFO on its host side.

---
 rtl/uart_tx_drain.sv | 151 +++++++++++++++
 tb/tb_uart_tx_drain.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops bytes from an upstream byte FIFO and serialises them
// as start / 8 data (LSB first) / optional parity / stop frames on a registered txd.
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] fByte,
  input  logic       fEmpty,
  output logic       fPop,
  output logic       txd,
  output logic       busy
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic          par, par_d;
  logic          txd_d;
  logic          bit_end;
  logic          start_ok;

  assign bit_end  = (cnt == CNT_LAST);
  assign start_ok = enable && !fEmpty;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      par   <= 1'b0;
      txd   <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shift <= shift_d;
      par   <= par_d;
      txd   <= txd_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift;
    par_d   = par;

    case (state)
      ST_IDLE: begin
        if (start_ok) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        shift_d = fByte;
        par_d   = (PARITY == 2) ? ~^fByte : ^fByte;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = ST_START;
      end

      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift[7:1]};
          if (idx == 3'd7) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx + 3'd1;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      ST_STOP: begin
        // idx counts stop bits here; FIFO is re-checked only on the final stop cycle
        if (bit_end) begin
          cnt_d = '0;
          if (idx == STOP_LAST) begin
            idx_d   = '0;
            state_d = start_ok ? ST_FETCH : ST_IDLE;
          end else begin
            idx_d = idx + 3'd1;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // txd is registered from the next state so the line changes exactly on bit boundaries
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  assign fPop = (state == ST_FETCH);
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: three parameter variants fed from FIFO models and compared
// cycle by cycle against an expected-waveform queue built from each frame's bit list.
module tb_uart_tx_drain;

  localparam int C = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] fbyte [3];
  logic [2:0] fempty = '1;
  logic [2:0] fpop;
  logic [2:0] txd;
  logic [2:0] busy;

  int par_cfg  [3] = '{0, 1, 2};
  int stop_cfg [3] = '{1, 2, 1};

  logic [7:0] dq   [3][$];   // bytes visible to the DUT FIFO port
  logic [7:0] rq   [3][$];   // reference copy consumed by the model
  logic [1:0] expq [3][$];   // per-cycle expectation {fPop, txd}; non-empty means busy

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  always #5 clock = ~clock;

  uart_tx_drain #(.CLKS_PER_BIT(C), .STOP_BITS(1), .PARITY(0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .fByte(fbyte[0]), .fEmpty(fempty[0]),
    .fPop(fpop[0]), .txd(txd[0]), .busy(busy[0]));

  uart_tx_drain #(.CLKS_PER_BIT(C), .STOP_BITS(2), .PARITY(1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .fByte(fbyte[1]), .fEmpty(fempty[1]),
    .fPop(fpop[1]), .txd(txd[1]), .busy(busy[1]));

  uart_tx_drain #(.CLKS_PER_BIT(C), .STOP_BITS(1), .PARITY(2)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .fByte(fbyte[2]), .fEmpty(fempty[2]),
    .fPop(fpop[2]), .txd(txd[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push_bit(input int i, input logic b);
    for (int k = 0; k < C; k++) expq[i].push_back({1'b0, b});
  endtask

  task automatic build_frame(input int i, input logic [7:0] b);
    expq[i].push_back(2'b11);   // pop cycle
    expq[i].push_back(2'b01);   // load cycle
    push_bit(i, 1'b0);
    for (int k = 0; k < 8; k++) push_bit(i, b[k]);
    if (par_cfg[i] == 1) push_bit(i, ^b);
    if (par_cfg[i] == 2) push_bit(i, ~^b);
    for (int s = 0; s < stop_cfg[i]; s++) push_bit(i, 1'b1);
  endtask

  // FIFO: registered head byte after a pop, garbage otherwise, registered empty flag
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (fpop[i] && dq[i].size() > 0) fbyte[i] <= dq[i].pop_front();
      else                             fbyte[i] <= 8'($urandom);
      fempty[i] <= (dq[i].size() == 0);
    end
  end

  // Reference: a new frame may start when nothing is pending or the last stop cycle ends
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        expq[i].delete();
      end else begin
        if (expq[i].size() > 0) expq[i].delete(0);
        if (expq[i].size() == 0 && enable && !fempty[i]) begin
          if (rq[i].size() == 0) check($sformatf("ref_underflow%0d", i), 1, 0);
          else                   build_frame(i, rq[i].pop_front());
        end
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        logic [1:0] e;
        e = (expq[i].size() > 0) ? expq[i][0] : 2'b01;
        check($sformatf("txd%0d", i),  32'(txd[i]),  32'(e[0]));
        check($sformatf("fpop%0d", i), 32'(fpop[i]), 32'(e[1]));
        check($sformatf("busy%0d", i), 32'(busy[i]), 32'(expq[i].size() > 0));
      end
    end
  end

  task automatic push(input logic [7:0] b);
    for (int i = 0; i < 3; i++) begin
      dq[i].push_back(b);
      rq[i].push_back(b);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy != 3'b000 || dq[0].size() > 0 || dq[1].size() > 0 || dq[2].size() > 0)
           && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", 32'(n < 3000), 1);
    for (int i = 0; i < 3; i++) check($sformatf("ref_left%0d", i), rq[i].size(), 0);
    repeat (4) @(negedge clock);
  endtask

  task automatic wait_pop0();
    int n = 0;
    while (!fpop[0] && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("pop_wait", 32'(fpop[0]), 1);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clock);
    checking = 1'b1;
    reset    = 1'b0;
    repeat (2) @(negedge clock);

    enable = 1'b1;
    push(8'h55);
    wait_idle();

    push(8'hA3);
    push(8'h0F);
    wait_idle();

    push(8'h07);
    wait_idle();

    repeat (100) @(negedge clock);

    // reset during the third data bit of 0xFF; the next byte must go out whole
    push(8'hFF);
    push(8'h3C);
    wait_pop0();
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_txd",  32'(txd),  32'(3'b111));
    check("rst_busy", 32'(busy), 0);
    wait_idle();

    // enable dropped in START of the first of three queued frames
    enable = 1'b0;
    push(8'h12);
    push(8'h34);
    push(8'h56);
    enable = 1'b1;
    wait_pop0();
    repeat (2) @(negedge clock);
    enable = 1'b0;
    repeat (120) @(negedge clock);
    check("held_fifo", dq[0].size(), 2);
    enable = 1'b1;
    wait_idle();

    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 19) == 0 && dq[0].size() < 6) push(8'($urandom));
      if ($urandom_range(0, 59) == 0) enable = ~enable;
    end
    enable = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
